// File: rtl/des_round_stage.sv
// One registered DES Feistel round (E, key XOR, S1..S8, P, XOR with L) behind a valid/ready handshake.
// Optional: define DES_ROUND_NOSWAP_EN to add in_noswap for the unswapped final round.
module des_round_stage #(
    parameter int REG_MID = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [32:1] in_l,
    input  logic [32:1] in_r,
    input  logic [48:1] in_k,
`ifdef DES_ROUND_NOSWAP_EN
    input  logic        in_noswap,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:1] out_l,
    output logic [32:1] out_r
);

    // S1 in the top 256 bits; within a box, row-major with entry 0 as the most significant nibble
    localparam logic [2047:0] SBOX = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    localparam logic [255:0] PTAB = {
        8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
        8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
        8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
        8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25
    };

    // E: group g takes DES bits 4g..4g+5 with wrap-around at both ends
    function automatic logic [48:1] expand(input logic [32:1] r);
        logic [48:1] e;
        int src;
        e = '0;
        for (int m = 0; m < 48; m++) begin
            src = 4 * (m / 6) + (m % 6);
            if (src == 0) src = 32;
            else if (src == 33) src = 1;
            e = {e[47:1], 1'(r >> (32 - src))};
        end
        return e;
    endfunction

    function automatic logic [32:1] sbox_layer(input logic [48:1] x);
        logic [32:1] s;
        logic [6:1]  g;
        int idx;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            g   = 6'(x >> (42 - 6 * j));
            idx = 64 * j + 16 * int'({g[6], g[1]}) + int'(g[5:2]);
            s   = {s[28:1], 4'(SBOX >> (2044 - 4 * idx))};
        end
        return s;
    endfunction

    function automatic logic [32:1] permute(input logic [32:1] s);
        logic [32:1] p;
        int src;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            src = int'(8'(PTAB >> (248 - 8 * i)));
            p   = {p[31:1], 1'(s >> (32 - src))};
        end
        return p;
    endfunction

    logic        load_out;
    logic        s2_vld;
    logic [32:1] s2_l;
    logic [32:1] s2_r;
    logic [48:1] s2_x;
`ifdef DES_ROUND_NOSWAP_EN
    logic        s2_ns;
`endif
    logic [32:1] f_val;
    logic [32:1] nxt_l;
    logic [32:1] nxt_r;

    assign load_out = !out_valid || out_ready;

    generate
        if (REG_MID != 0) begin : g_mid
            logic        vld_p1;
            logic [32:1] l_p1;
            logic [32:1] r_p1;
            logic [48:1] x_p1;
`ifdef DES_ROUND_NOSWAP_EN
            logic        ns_p1;
`endif
            logic        load_p1;

            assign load_p1 = !vld_p1 || load_out;

            // stage 1: expansion and key mix
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_p1 <= 1'b0;
                    l_p1   <= '0;
                    r_p1   <= '0;
                    x_p1   <= '0;
`ifdef DES_ROUND_NOSWAP_EN
                    ns_p1  <= 1'b0;
`endif
                end else if (load_p1) begin
                    vld_p1 <= in_valid;
                    if (in_valid) begin
                        l_p1  <= in_l;
                        r_p1  <= in_r;
                        x_p1  <= expand(in_r) ^ in_k;
`ifdef DES_ROUND_NOSWAP_EN
                        ns_p1 <= in_noswap;
`endif
                    end
                end
            end

            assign in_ready = load_p1;
            assign s2_vld   = vld_p1;
            assign s2_l     = l_p1;
            assign s2_r     = r_p1;
            assign s2_x     = x_p1;
`ifdef DES_ROUND_NOSWAP_EN
            assign s2_ns    = ns_p1;
`endif
        end else begin : g_nomid
            assign in_ready = load_out;
            assign s2_vld   = in_valid;
            assign s2_l     = in_l;
            assign s2_r     = in_r;
            assign s2_x     = expand(in_r) ^ in_k;
`ifdef DES_ROUND_NOSWAP_EN
            assign s2_ns    = in_noswap;
`endif
        end
    endgenerate

    assign f_val = permute(sbox_layer(s2_x));
`ifdef DES_ROUND_NOSWAP_EN
    assign nxt_l = s2_ns ? (s2_l ^ f_val) : s2_r;
    assign nxt_r = s2_ns ? s2_r : (s2_l ^ f_val);
`else
    assign nxt_l = s2_r;
    assign nxt_r = s2_l ^ f_val;
`endif

    // stage 2: substitution, permutation and half swap into the output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_l     <= '0;
            out_r     <= '0;
        end else if (load_out) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_l <= nxt_l;
                out_r <= nxt_r;
            end
        end
    end

endmodule

// File: tb/tb_des_round_stage.sv
// Bench for des_round_stage: FIPS round vectors, backpressure, reset, and random streams on
// REG_MID=1 and REG_MID=0 instances against a table-driven DES round model with scoreboards.
module tb_des_round_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ns;
    logic [32:1] a_in_l, a_in_r, a_out_l, a_out_r;
    logic [48:1] a_in_k;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ns;
    logic [32:1] b_in_l, b_in_r, b_out_l, b_out_r;
    logic [48:1] b_in_k;

    int n_vec = 0;
    int n_err = 0;

    bit   [63:0] qa[$];
    bit   [63:0] qb[$];
    bit          a_hold, b_hold;
    logic [63:0] a_held, b_held;

    des_round_stage #(.REG_MID(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_l(a_in_l), .in_r(a_in_r), .in_k(a_in_k),
`ifdef DES_ROUND_NOSWAP_EN
        .in_noswap(a_ns),
`endif
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_l(a_out_l), .out_r(a_out_r)
    );

    des_round_stage #(.REG_MID(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_l(b_in_l), .in_r(b_in_r), .in_k(b_in_k),
`ifdef DES_ROUND_NOSWAP_EN
        .in_noswap(b_ns),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_l(b_out_l), .out_r(b_out_r)
    );

    int E_T[48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9, 10, 11, 12, 13,
                    12, 13, 14, 15, 16, 17,  16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
                    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1};
    int P_T[32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    string S_T[8] = '{
        "E4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D",
        "F18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9",
        "A09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C",
        "7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E",
        "2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453",
        "C1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D",
        "4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C",
        "D2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B"};

    function automatic int hexval(input byte c);
        if (c >= 8'h41) return int'(c) - 55;
        return int'(c) - 48;
    endfunction

    // Reference round in DES bit numbering: returns {out_l, out_r}
    function automatic logic [63:0] model(input logic [32:1] l, input logic [32:1] r,
                                          input logic [48:1] k, input bit noswap);
        bit eb[1:48];
        bit sb[1:32];
        logic [32:1] f;
        int row, col, v, base;
        for (int m = 1; m <= 48; m++) eb[m] = r[33 - E_T[m-1]] ^ k[49 - m];
        for (int j = 1; j <= 8; j++) begin
            base = 6 * j - 5;
            row  = 2 * int'(eb[base]) + int'(eb[base+5]);
            col  = 8 * int'(eb[base+1]) + 4 * int'(eb[base+2]) + 2 * int'(eb[base+3]) + int'(eb[base+4]);
            v    = hexval(S_T[j-1].getc(row * 16 + col));
            for (int t = 0; t < 4; t++) sb[4*j-3+t] = v[3-t];
        end
        for (int i = 1; i <= 32; i++) f[33 - i] = sb[P_T[i-1]];
        if (noswap) return {l ^ f, r};
        return {r, l ^ f};
    endfunction

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon_one(input string nm, input logic iv, input logic ir,
                           input logic [32:1] il, input logic [32:1] irr, input logic [48:1] ik,
                           input bit ns, input logic ov, input logic ordy,
                           input logic [32:1] ol, input logic [32:1] orr,
                           inout bit [63:0] q[$], inout bit hold, inout logic [63:0] held);
        bit [63:0] e;
        if (!rst_n) begin
            q.delete();
            hold = 1'b0;
            return;
        end
        if (hold) check({nm, "_hold"}, {ov, ol, orr}, {1'b1, held});
        if (ov && ordy) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_extra: got %h expected no output", nm, {ol, orr});
            end else begin
                e = q.pop_front();
                check({nm, "_data"}, {ol, orr}, e);
            end
        end
        hold = ov && !ordy;
        held = {ol, orr};
        if (iv && ir) q.push_back(model(il, irr, ik, ns));
    endtask

    task automatic step();
        @(negedge clk);
        mon_one("a", a_in_valid, a_in_ready, a_in_l, a_in_r, a_in_k, a_ns,
                a_out_valid, a_out_ready, a_out_l, a_out_r, qa, a_hold, a_held);
        mon_one("b", b_in_valid, b_in_ready, b_in_l, b_in_r, b_in_k, b_ns,
                b_out_valid, b_out_ready, b_out_l, b_out_r, qb, b_hold, b_held);
        if (rst_n) check("b_ready_rule", b_in_ready, !b_out_valid || b_out_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [32:1] l, input logic [32:1] r, input logic [48:1] k);
        a_in_l = l; a_in_r = r; a_in_k = k; a_in_valid = 1'b1;
    endtask

    logic [32:1] tl[3], tr[3];
    logic [48:1] tk[3];

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_out_ready = 1; a_in_l = '0; a_in_r = '0; a_in_k = '0; a_ns = 0;
        b_in_valid = 0; b_out_ready = 1; b_in_l = '0; b_in_r = '0; b_in_k = '0; b_ns = 0;
        repeat (3) step();
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_l", a_out_l, 0);
        check("rst_a_r", a_out_r, 0);
        check("rst_b_valid", b_out_valid, 0);
        check("rst_a_ready", a_in_ready, 1);
        rst_n = 1'b1;

        check("model_round1", model(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0),
              64'hF0AAF0AA_EF4A6544);
        check("model_round2", model(32'hF0AAF0AA, 32'hEF4A6544, 48'h79AED9DBC9E5, 1'b0),
              64'hEF4A6544_CC017709);

        // FIPS round 1, two-cycle latency
        drive_a(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072);
        check("fips_in_ready", a_in_ready, 1);
        step();
        a_in_valid = 0;
        check("fips_not_yet", a_out_valid, 0);
        step();
        check("fips_valid", a_out_valid, 1);
        check("fips_out_l", a_out_l, 32'hF0AAF0AA);
        check("fips_out_r", a_out_r, 32'hEF4A6544);
        step();
        check("fips_gone", a_out_valid, 0);

        // two-round stream at full flow
        drive_a(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072);
        step();
        check("stream_ready", a_in_ready, 1);
        drive_a(32'hF0AAF0AA, 32'hEF4A6544, 48'h79AED9DBC9E5);
        step();
        a_in_valid = 0;
        check("stream_r1", {a_out_valid, a_out_r}, {1'b1, 32'hEF4A6544});
        step();
        check("stream_r2", {a_out_valid, a_out_r}, {1'b1, 32'hCC017709});
        step();

        // backpressure: three back-to-back with out_ready low
        for (int i = 0; i < 3; i++) begin
            tl[i] = $urandom; tr[i] = $urandom; tk[i] = {16'($urandom), 32'($urandom)};
        end
        a_out_ready = 0;
        drive_a(tl[0], tr[0], tk[0]);
        step();
        drive_a(tl[1], tr[1], tk[1]);
        check("bp_ready_second", a_in_ready, 1);
        step();
        drive_a(tl[2], tr[2], tk[2]);
        check("bp_full", a_in_ready, 0);
        step();
        check("bp_full_again", a_in_ready, 0);
        check("bp_first_held", {a_out_valid, a_out_l, a_out_r}, {1'b1, model(tl[0], tr[0], tk[0], 1'b0)});
        step();
        a_out_ready = 1;
        for (int i = 0; i < 5 && !a_in_ready; i++) step();
        check("bp_release", a_in_ready, 1);
        step();
        a_in_valid = 0;
        repeat (4) step();
        check("bp_drained", qa.size(), 0);

        // reset mid-flight
        drive_a(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072);
        step();
        a_in_valid = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        check("rmid_valid", a_out_valid, 0);
        check("rmid_l", a_out_l, 0);
        check("rmid_r", a_out_r, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rmid_silent", a_out_valid, 0);
        end

`ifdef DES_ROUND_NOSWAP_EN
        drive_a(32'hCC00CCFF, 32'hF0AAF0AA, 48'h1B02EFFC7072);
        a_ns = 1;
        step();
        a_in_valid = 0;
        a_ns = 0;
        step();
        check("noswap_l", a_out_l, 32'hEF4A6544);
        check("noswap_r", a_out_r, 32'hF0AAF0AA);
        step();
`endif

        // single-register variant: one cycle latency
        b_in_l = 32'hCC00CCFF; b_in_r = 32'hF0AAF0AA; b_in_k = 48'h1B02EFFC7072; b_in_valid = 1;
        step();
        b_in_valid = 0;
        check("b_valid", b_out_valid, 1);
        check("b_out_l", b_out_l, 32'hF0AAF0AA);
        check("b_out_r", b_out_r, 32'hEF4A6544);
        step();

        // random valid/ready streams on both variants, one reset pulse midway
        for (int c = 0; c < 600; c++) begin
            a_in_valid  = ($urandom_range(0, 99) < 70);
            a_out_ready = ($urandom_range(0, 99) < 65);
            a_in_l = $urandom; a_in_r = $urandom; a_in_k = {16'($urandom), 32'($urandom)};
            b_in_valid  = ($urandom_range(0, 99) < 70);
            b_out_ready = ($urandom_range(0, 99) < 65);
            b_in_l = $urandom; b_in_r = $urandom; b_in_k = {16'($urandom), 32'($urandom)};
`ifdef DES_ROUND_NOSWAP_EN
            a_ns = 1'($urandom);
            b_ns = 1'($urandom);
`endif
            rst_n = (c != 300);
            step();
        end
        rst_n = 1;
        a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
        repeat (5) step();
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/des_round_stage.md
Name: des_round_stage

Overview:
- One registered DES Feistel round with a valid/ready handshake. Chain 16 instances, or iterate one, between the IP and FP stages.
- Upstream half: expansion E and subkey XOR, producing eight 6-bit groups.
- Those groups feed eight S-box instances, S1..S8, of the existing module family (6-bit in, 4-bit out).
- Downstream half: permutation P and XOR with L, producing the swapped halves for the next round.

Parameters:
- REG_MID, 1, 1 = pipeline register between E/XOR and S-box/P/XOR (latency 2); 0 = no mid register (latency 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low, sampled on rising clk edge
- in_valid  in  1  input transaction valid
- in_ready  out  1  stage can accept input this cycle
- in_l  in  [32:1]  left half; bit 32 = DES bit 1 (MSB-first)
- in_r  in  [32:1]  right half; same numbering
- in_k  in  [48:1]  round subkey; bit 48 = DES bit 1
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts output
- out_l  out  [32:1]  new left half = in_r
- out_r  out  [32:1]  new right half = in_l ^ P(S(E(in_r) ^ in_k))

Behaviour:
- Reset: synchronous, active-low; clk is the only clock. While rst_n=0 at a rising edge, all valid flags clear. The stage-1 payload registers and the output registers (out_l, out_r) clear to 0, so out_l=0, out_r=0 and out_valid=0 after reset.
- in_ready is combinational from internal state and out_ready only.
- Reset mid-operation discards all in-flight transactions; nothing is emitted afterwards.
- Bit mapping: all tables use FIPS 46-3 positions, DES bit n = vector bit (W+1-n).
- S-box input: 6-bit group j (j=1..8) = DES bits 6j-5..6j of E^K. It drives Sj.in[6:1] with DES bit 6j-5 on in[6]. Sj.out[4:1] lands on DES bits 4j-3..4j of the pre-P word, out[4] first.
- REG_MID=1, stage 1: registers v1, l1 = in_l, r1 = in_r, x1 = E(in_r) ^ in_k.
- REG_MID=1, stage 2: out_l = r1, out_r = l1 ^ P(S(x1)), where S is the S1..S8 outputs concatenated.
- Pipeline advance rules:
  - out regs load when !out_valid || out_ready.
  - Stage 1 loads when !v1 || (stage 2 loads).
  - in_ready = !v1 || (!out_valid || out_ready).
- Throughput is 1 transaction/cycle with out_ready held high. Latency is 2 cycles from input handshake to out_valid.
- REG_MID=0: a single register stage. in_ready = !out_valid || out_ready; latency 1.
- Handshake fires on valid && ready at a rising edge. While out_valid=1 && out_ready=0, out_l/out_r/out_valid must hold stable. in_l/in_r/in_k are sampled only on an accepted handshake.
- Simultaneous accept and emit in the same cycle is legal; there are no bubbles at full flow.
- Full: with both stages holding data and out_ready=0, in_ready=0 and no input is lost.
- Empty: out_valid=0, and out_l/out_r keep their last values, which are don't-care.
- No internal state beyond pipeline registers; no counters, no key schedule.

Optional Feature:
- Macro: DES_ROUND_NOSWAP_EN.
- Defined: adds input port in_noswap (1 bit), sampled and carried with the transaction like the data. When 1, outputs are unswapped for DES round 16: out_l = in_l ^ f, out_r = in_r. When 0, normal swap.
- Undefined: the port is absent and the output is always swapped.

Test Plan:
- FIPS worked example, round 1: in_l=CC00CCFF, in_r=F0AAF0AA, in_k=1B02EFFC7072 -> out_l=F0AAF0AA, out_r=EF4A6544, exactly 2 cycles after accept (REG_MID=1).
- Two-round stream, out_ready=1:
  - Cycle N: the round-1 vector.
  - Cycle N+1: in_l=F0AAF0AA, in_r=EF4A6544, in_k=79AED9DBC9E5.
  - Response: out_r values EF4A6544 then CC017709 on consecutive cycles; in_ready stays 1.
- Backpressure:
  - Send 3 back-to-back transactions with out_ready=0.
  - Response: in_ready drops to 0 after 2 are accepted; the third is held upstream. The first output stays stable on out_l/out_r.
  - Release out_ready: all 3 emerge in order, no loss or duplication.
- Reset mid-flight: accept the round-1 vector, then pull rst_n low for 1 cycle -> out_valid=0, out_l=0, out_r=0, and no later output for that transaction.
- With DES_ROUND_NOSWAP_EN: round-1 vector with in_noswap=1 -> out_l=EF4A6544, out_r=F0AAF0AA.
- REG_MID=0: round-1 vector -> same result 1 cycle after accept; random valid/ready stream matches a golden model with no drops.
